// File: rtl/seg7_scan_mux.sv
// Multiplexed 7-segment scanner: one digit per SCAN_DIV-cycle slot,
// frame-aligned display updates with a load-anywhere pending register.
// Optional leading-zero blanking when SEG7_LZ_BLANK_EN is defined.
// Ports: clk, rst_n (async, active-low), enable, hex_mode, load,
//   value_in[4*NUM_DIGITS], dp_in[NUM_DIGITS] -> seg_out[7] {a..g},
//   dp_out, digit_sel[NUM_DIGITS] (all active-low), frame_done.
module seg7_scan_mux #(
  parameter int NUM_DIGITS = 4,
  parameter int SCAN_DIV   = 50000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable,
  input  logic                    hex_mode,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] value_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  output logic [6:0]              seg_out,
  output logic                    dp_out,
  output logic [NUM_DIGITS-1:0]   digit_sel,
  output logic                    frame_done
);

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  logic [PW-1:0]           presc;
  logic [IW-1:0]           idx;
  logic [4*NUM_DIGITS-1:0] pend_val;
  logic [NUM_DIGITS-1:0]   pend_dp;
  logic [4*NUM_DIGITS-1:0] disp_val;
  logic [NUM_DIGITS-1:0]   disp_dp;

  logic tick;
  logic last;
  logic wrap;

  assign tick = (presc == PW'(SCAN_DIV - 1));
  assign last = (idx == IW'(NUM_DIGITS - 1));
  assign wrap = enable & tick & last;

  function automatic logic [6:0] glyph(input logic [3:0] n);
    logic [6:0] g;
    unique case (n)
      4'h0: g = 7'h7E;
      4'h1: g = 7'h30;
      4'h2: g = 7'h6D;
      4'h3: g = 7'h79;
      4'h4: g = 7'h33;
      4'h5: g = 7'h5B;
      4'h6: g = 7'h5F;
      4'h7: g = 7'h70;
      4'h8: g = 7'h7F;
      4'h9: g = 7'h7B;
      4'hA: g = 7'h77;
      4'hB: g = 7'h1F;
      4'hC: g = 7'h4E;
      4'hD: g = 7'h3D;
      4'hE: g = 7'h4F;
      default: g = 7'h47;
    endcase
    return g;
  endfunction

  logic [NUM_DIGITS-1:0] lz;

`ifdef SEG7_LZ_BLANK_EN
  // lz[k]: nibble k and every nibble above it are zero
  always_comb begin
    logic zero_above;
    zero_above = 1'b1;
    lz = '0;
    for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
      zero_above = zero_above & (disp_val[4*k +: 4] == 4'h0);
      lz[k] = zero_above;
    end
  end
`else
  assign lz = '0;
`endif

  logic [3:0]            cur_nib;
  logic                  cur_dp;
  logic                  cur_lz;
  logic [NUM_DIGITS-1:0] sel_n;

  always_comb begin
    cur_nib = 4'h0;
    cur_dp  = 1'b0;
    cur_lz  = 1'b0;
    sel_n   = '1;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (idx == IW'(k)) begin
        cur_nib  = disp_val[4*k +: 4];
        cur_dp   = disp_dp[k];
        cur_lz   = lz[k];
        sel_n[k] = 1'b0;
      end
    end
  end

  logic blank;
  assign blank = cur_lz | (~hex_mode & (cur_nib > 4'd9));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc <= '0;
      idx   <= '0;
    end else if (!enable) begin
      presc <= '0;
      idx   <= '0;
    end else if (tick) begin
      presc <= '0;
      idx   <= last ? '0 : idx + IW'(1);
    end else begin
      presc <= presc + PW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_val <= '0;
      pend_dp  <= '0;
    end else if (load) begin
      pend_val <= value_in;
      pend_dp  <= dp_in;
    end
  end

  // A same-edge load bypasses pending so it is not lost at the wrap
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      disp_val <= '0;
      disp_dp  <= '0;
    end else if (!enable || wrap) begin
      disp_val <= load ? value_in : pend_val;
      disp_dp  <= load ? dp_in : pend_dp;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_out    <= 7'h7F;
      dp_out     <= 1'b1;
      digit_sel  <= '1;
      frame_done <= 1'b0;
    end else begin
      frame_done <= wrap;
      if (enable) begin
        seg_out   <= blank ? 7'h7F : ~glyph(cur_nib);
        dp_out    <= ~cur_dp;
        digit_sel <= sel_n;
      end else begin
        seg_out   <= 7'h7F;
        dp_out    <= 1'b1;
        digit_sel <= '1;
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_mux.sv
// Scoreboard bench for seg7_scan_mux (4 digits, 4 cycles/slot).
// Reference model works from slot arithmetic on a cycle count.
module tb_seg7_scan_mux;

  localparam int N  = 4;
  localparam int SD = 4;
  localparam int F  = N * SD;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           enable = 1'b0;
  logic           hex_mode = 1'b0;
  logic           load = 1'b0;
  logic [4*N-1:0] value_in = '0;
  logic [N-1:0]   dp_in = '0;
  logic [6:0]     seg_out;
  logic           dp_out;
  logic [N-1:0]   digit_sel;
  logic           frame_done;

  seg7_scan_mux #(.NUM_DIGITS(N), .SCAN_DIV(SD)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .hex_mode(hex_mode), .load(load), .value_in(value_in),
    .dp_in(dp_in), .seg_out(seg_out), .dp_out(dp_out),
    .digit_sel(digit_sel), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [6:0]   seg;
    logic         dp;
    logic [N-1:0] sel;
    logic         fd;
  } obs_t;

  logic [6:0] gl [16] = '{
    7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
    7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};

  obs_t q[$];
  int pass_cnt = 0;
  int total = 0;

  logic [4*N-1:0] m_pend, m_disp;
  logic [N-1:0]   m_pdp, m_ddp;
  int             m_cnt;

  function automatic obs_t dark_obs();
    obs_t o;
    o.seg = 7'h7F;
    o.dp  = 1'b1;
    o.sel = '1;
    o.fd  = 1'b0;
    return o;
  endfunction

  function automatic obs_t model_out();
    obs_t o;
    int s;
    logic [3:0] d;
    logic bl;
    o = dark_obs();
    if (enable) begin
      s  = (m_cnt / SD) % N;
      d  = 4'((m_disp >> (4 * s)) & 16'hF);
      bl = (!hex_mode && d > 4'd9);
`ifdef SEG7_LZ_BLANK_EN
      if (s > 0 && (m_disp >> (4 * s)) == 0) bl = 1'b1;
`endif
      o.seg = bl ? 7'h7F : ~gl[d];
      o.dp  = ~m_ddp[s];
      o.sel = ~(N'(1) << s);
      o.fd  = ((m_cnt % F) == F - 1);
    end
    return o;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      q.push_back(dark_obs());
      m_pend = '0; m_disp = '0;
      m_pdp = '0; m_ddp = '0;
      m_cnt = 0;
    end else begin
      q.push_back(model_out());
      if (!enable || ((m_cnt % F) == F - 1)) begin
        m_disp = load ? value_in : m_pend;
        m_ddp  = load ? dp_in : m_pdp;
      end
      if (load) begin
        m_pend = value_in;
        m_pdp  = dp_in;
      end
      m_cnt = enable ? m_cnt + 1 : 0;
    end
  end

  task automatic check(input string nm, input obs_t e);
    obs_t g;
    g = {seg_out, dp_out, digit_sel, frame_done};
    total++;
    if (g === e) pass_cnt++;
    else
      $display("FAIL %s t=%0t: got seg=%h dp=%b sel=%h fd=%b, want seg=%h dp=%b sel=%h fd=%b",
               nm, $time, g.seg, g.dp, g.sel, g.fd, e.seg, e.dp, e.sel, e.fd);
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) check("outputs", q.pop_front());
  end

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      load = 1'b0;
    end
  endtask

  task automatic do_load(input logic [4*N-1:0] v, input logic [N-1:0] d);
    value_in = v;
    dp_in = d;
    load = 1'b1;
    cycles(1);
  endtask

  // Advance until the next edge is at frame position p
  task automatic wait_pos(input int p);
    int k;
    k = 0;
    while ((m_cnt % F) != p && k < 100) begin
      cycles(1);
      k++;
    end
    total++;
    if (k < 100) pass_cnt++;
    else $display("FAIL wait_pos: got timeout, want position %0d", p);
  endtask

  int fdc, last_fd, gap_bad;

  initial begin
    cycles(3);
    check("reset_dark", dark_obs());
    rst_n = 1'b1;
    enable = 1'b1;
    cycles(20);
    do_load(16'h1234, 4'b0000);
    cycles(40);
    hex_mode = 1'b0;
    do_load(16'h00A0, 4'b0000);
    cycles(32);
    hex_mode = 1'b1;
    cycles(32);
    wait_pos(5);
    do_load(16'h5555, 4'b1111);
    wait_pos(F - 1);
    do_load(16'h6666, 4'b0000);
    cycles(32);
    do_load(16'h0050, 4'b0100);
    cycles(36);
    fdc = 0; last_fd = -1; gap_bad = 0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (frame_done) begin
        if (last_fd >= 0 && i - last_fd != F) gap_bad++;
        last_fd = i;
        fdc++;
      end
    end
    total++;
    if (fdc == 4 && gap_bad == 0) pass_cnt++;
    else $display("FAIL frame_count: got %0d pulses (%0d bad gaps), want 4 (0)", fdc, gap_bad);
    cycles(1);
    wait_pos(6);
    enable = 1'b0;
    cycles(10);
    enable = 1'b1;
    cycles(20);
    for (int i = 0; i < 500; i++) begin
      enable = ($urandom_range(0, 19) != 0);
      if ($urandom_range(0, 7) == 0) hex_mode = $urandom_range(0, 1);
      if ($urandom_range(0, 3) == 0) begin
        value_in = $urandom;
        if ($urandom_range(0, 1) == 0) value_in = value_in & 16'h00FF;
        dp_in = $urandom;
        load = 1'b1;
      end
      cycles(1);
    end
    enable = 1'b1;
    do_load(16'h9ABC, 4'b1010);
    cycles(7);
    #1;
    rst_n = 1'b0;
    #1;
    check("reset_async", dark_obs());
    cycles(2);
    rst_n = 1'b1;
    cycles(40);
    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
